sobel_window_ctrl: RTL

Window scheduler for the Sobel edge pipeline. It accepts a raster-order 8-bit grayscale pixel stream and keeps two line buffers. It assembles each 3x3 neighbourhood into P0..P8 and raises `start_calculations` so the downstream horizontal and vertical gradient units evaluate exactly one valid window per interior pixel. It sits between the pixel source and the gradient and magnitude stage, and owns all row/column sequencing, frame framing and backpressure.

---
 rtl/sobel_window_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// 3x3 Sobel window scheduler: raster pixels in, one registered window per interior pixel, valid the cycle after the accept.
// pix_ready = !start_calculations || win_ready (0 while draining the last window); win_count only with SOBEL_WIN_STATS_EN.
module sobel_window_ctrl #(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [7:0]  P0,
  output logic [7:0]  P1,
  output logic [7:0]  P2,
  output logic [7:0]  P3,
  output logic [7:0]  P4,
  output logic [7:0]  P5,
  output logic [7:0]  P6,
  output logic [7:0]  P7,
  output logic [7:0]  P8,
  output logic        start_calculations,
  input  logic        win_ready,
  output logic        frame_done
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic [19:0] win_count
`endif
);

  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(FRAME_H);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, LAST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt, eff_col;
  logic [RW-1:0] row, row_nxt, eff_row;
  logic          accept, sof_hit, process, emit, consume, last_pix, leave_last;
  logic [7:0]    lb0 [LINE_W];
  logic [7:0]    lb1 [LINE_W];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win [9];

  assign consume   = start_calculations && win_ready;
  assign pix_ready = (state != LAST) && (!start_calculations || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign sof_hit   = accept && pix_sof;
  // In IDLE only a start-of-frame pixel is taken into the pipeline; others are dropped.
  assign process   = accept && ((state != IDLE) || pix_sof);

  // A start-of-frame pixel restarts the raster at (0,0) whatever the counters say.
  assign eff_col  = sof_hit ? '0 : col;
  assign eff_row  = sof_hit ? '0 : row;
  assign last_pix = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
  assign emit     = process && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  assign leave_last = (state == LAST) && (!start_calculations || win_ready);

  assign lb0_rd = lb0[eff_col];
  assign lb1_rd = lb1[eff_col];

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    if (process) begin
      if (eff_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col_nxt = eff_col + CW'(1);
        row_nxt = eff_row;
      end
      if (last_pix) begin
        state_nxt = LAST;
      end else if (row_nxt >= RW'(2)) begin
        state_nxt = RUN;
      end else begin
        state_nxt = FILL;
      end
    end else if (leave_last) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state              <= IDLE;
      col                <= '0;
      row                <= '0;
      start_calculations <= 1'b0;
      frame_done         <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      frame_done <= leave_last;
      if (emit) begin
        start_calculations <= 1'b1;
      end else if (consume) begin
        start_calculations <= 1'b0;
      end
      // Columns slide left; the new right column is lb1 (oldest), lb0, then the live pixel.
      if (process) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_in;
      end
    end
  end

  // Line buffers need no reset: FILL rows mask whatever they hold.
  always_ff @(posedge clk) begin
    if (process) begin
      lb1[eff_col] <= lb0_rd;
      lb0[eff_col] <= pix_in;
    end
  end

`ifdef SOBEL_WIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win_count <= '0;
    end else if (sof_hit) begin
      win_count <= '0;
    end else if (consume && (win_count != 20'hFFFFF)) begin
      win_count <= win_count + 20'd1;
    end
  end
`endif

  assign P0 = win[0];
  assign P1 = win[1];
  assign P2 = win[2];
  assign P3 = win[3];
  assign P4 = win[4];
  assign P5 = win[5];
  assign P6 = win[6];
  assign P7 = win[7];
  assign P8 = win[8];

endmodule
